alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Decode-to-execute pipeline register that sits directly upstream of the core ALU. It latches a decoded instruction beat, derives the 5-bit ALU operation code and operand-source selection from the instruction word, and applies MEM/WB result forwarding to both register operands. It presents `alu_op1`, `alu_op2` and `alu_sel` to the ALU under a valid/ready handshake with stall and flush support.

## Interface
- `DATA_W`, 32: datapath width; fixed at 32 for RV32I.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: decode beat valid.
- `in_ready` output 1: stage can accept a beat.
- `in_inst` input 32: raw instruction word.
- `in_pc` input 32: PC of the instruction.
- `in_rs1_data`, `in_rs2_data` input 32 each: register-file read data.
- `in_imm` input 32: sign-extended immediate from the immediate generator.
- `flush` input 1: kill the held beat and any beat offered this cycle.
- `fwd_mem_we`, `fwd_wb_we` input 1 each: forwarding source writes a register.
- `fwd_mem_rd`, `fwd_wb_rd` input 5 each: forwarding destination index.
- `fwd_mem_data`, `fwd_wb_data` input 32 each: forwarding value.
- `out_valid` output 1: ALU operands valid.
- `out_ready` input 1: execute stage consumes the beat.
- `alu_op1`, `alu_op2` output 32 each: ALU operands.
- `alu_sel` output 5: ALU operation code.
- `out_rd` output 5: destination register.
- `out_rd_we` output 1: writeback enable.
- `out_pc` output 32: PC of the held beat.
- `out_store_data` output 32: forwarded rs2 value for stores.

## Operation
- ALU code map: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10. Codes 11-31 are unused and never driven.
- OP (0110011): funct3 selects the code. `inst[30]` selects SUB for funct3 000 and SRA for funct3 101. op1 = rs1, op2 = rs2.
- OP-IMM (0010011): same map, except funct3 000 is always ADD. op1 = rs1, op2 = imm.
- LUI: PASSB, op2 = imm.
- AUIPC: ADD, op1 = pc, op2 = imm.
- JAL, JALR: ADD, op1 = pc, op2 = 4.
- LOAD, STORE: ADD, op1 = rs1, op2 = imm.
- BRANCH: ADD, op1 = pc, op2 = imm (target computation).
- Any other opcode: ADD, op1 = 0, op2 = 0, `out_rd_we` = 0.
- `out_rd_we` = 0 for STORE, BRANCH, illegal opcodes, or when rd = 0.
- The decode result (code, source selects, rd, rd_we) is registered at capture. Register values rs1/rs2 are also registered, raw.
- Forwarding is combinational on the registered rs fields and is re-evaluated every cycle while the beat is held:
  - MEM match has priority over WB match.
  - A source matches only when its `we` = 1, its rd equals the rs index, and the rs index is non-zero.
  - With no match, the registered register-file value is used.
- rs2 forwarding applies to both `alu_op2` (when the source is rs2) and `out_store_data`.

## Timing
- `in_ready` = !`out_valid` | `out_ready`. Capture occurs when `in_valid` & `in_ready` & !`flush`.
- Latency 1: a beat accepted at edge N drives `out_valid` = 1 after edge N.
- Back-to-back: with `out_ready` held 1, one beat per cycle with no bubbles.
- Stall: while `out_valid` & !`out_ready`, all registered fields hold. Only forwarded operand values may change.
- Flush: `out_valid` = 0 after the edge. Any same-cycle input beat is dropped, though `in_ready` still reflects the rule above. Flush has priority over both capture and hold.
- Consume without a new beat (`out_ready` = 1, no capture): `out_valid` = 0 after the edge.
- Reset (asynchronous, any time including mid-stall):
  - `out_valid` = 0 and all registered fields = 0.
  - Hence `alu_sel` = 0 (ADD), `alu_op1` = `alu_op2` = 0, `out_rd_we` = 0, `out_pc` = 0.
  - `in_ready` = 1 immediately after reset.

## Test plan
- `add x3,x1,x2` with rs1 = 5, rs2 = 7, no forwarding -> one cycle later `out_valid` = 1, `alu_sel` = 0, op1 = 5, op2 = 7, `out_rd` = 3, `out_rd_we` = 1.
- `srai x4,x1,3` (inst[30] = 1) -> `alu_sel` = 7, op2 = 3. Then `sub` -> `alu_sel` = 1. Then `addi` with inst[30] = 1 -> `alu_sel` = 0.
- Forwarding on `add x5,x1,x2`:
  - MEM rd = 1 with 0xAAAA and WB rd = 1 with 0xBBBB -> op1 = 0xAAAA.
  - WB rd = 2 with 0x1234 -> op2 = 0x1234.
  - MEM rd = 0 with `we` = 1 -> no forwarding.
- Stall then flush: `out_ready` = 0 for 3 cycles -> `in_ready` = 0 and fields stable. A `flush` pulse together with `in_valid` = 1 -> `out_valid` = 0 next cycle, and the offered beat never appears.
- `jal x1` at pc 0x100 -> op1 = 0x100, op2 = 4, `alu_sel` = 0. `sw` -> `out_rd_we` = 0 and `out_store_data` = forwarded rs2. An illegal opcode -> op1 = op2 = 0, `out_rd_we` = 0.
- Assert `rst` mid-stall -> asynchronously `out_valid` = 0, `alu_sel` = 0, operands 0, `in_ready` = 1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Decode-to-execute pipeline register in front of the core ALU. A decoded
// beat is captured under a valid/ready handshake, the ALU operation code and
// operand sources are derived from the instruction word at capture, and
// MEM/WB forwarding is applied combinationally to the held register operands
// so that a stalled beat always presents the freshest register values.
`timescale 1ns/1ps

module alu_operand_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Decode side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              flush,

    // Forwarding sources
    input  logic              fwd_mem_we,
    input  logic [4:0]        fwd_mem_rd,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [4:0]        fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_wb_data,

    // Execute side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [4:0]        alu_sel,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_store_data
);

    // ------------------------------------------------------------------
    // ALU operation codes (11..31 are never produced)
    // ------------------------------------------------------------------
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [DATA_W-1:0] CONST_FOUR = DATA_W'(32'd4);
    localparam logic [DATA_W-1:0] CONST_ZERO = DATA_W'(32'd0);

    // Source selects; the all-zero encoding is the zero operand so that the
    // reset state of the register naturally presents zero operands.
    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS1  = 2'd1,
        OP1_PC   = 2'd2
    } op1_src_e;

    typedef enum logic [1:0] {
        OP2_ZERO = 2'd0,
        OP2_RS2  = 2'd1,
        OP2_IMM  = 2'd2,
        OP2_FOUR = 2'd3
    } op2_src_e;

    typedef struct packed {
        logic [4:0] sel;
        op1_src_e   op1_src;
        op2_src_e   op2_src;
        logic       rd_we;
    } dec_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // funct3 -> ALU code; alt (inst[30]) picks SUB / SRA where allowed.
    function automatic logic [4:0] funct3_code(input logic [2:0] f3,
                                               input logic       alt_add,
                                               input logic       alt_shr);
        logic [4:0] code;
        case (f3)
            3'b000:  code = alt_add ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt_shr ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Full instruction decode into ALU code, operand sources and rd enable.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic       writes_rd;
        logic [4:0] rd;
        rd        = inst[11:7];
        writes_rd = 1'b1;
        d.sel     = ALU_ADD;
        d.op1_src = OP1_ZERO;
        d.op2_src = OP2_ZERO;
        case (inst[6:0])
            OPC_OP: begin
                d.sel     = funct3_code(inst[14:12], inst[30], inst[30]);
                d.op1_src = OP1_RS1;
                d.op2_src = OP2_RS2;
            end
            OPC_OPIMM: begin
                // No SUBI: funct3 000 is ADD regardless of inst[30]
                d.sel     = funct3_code(inst[14:12], 1'b0, inst[30]);
                d.op1_src = OP1_RS1;
                d.op2_src = OP2_IMM;
            end
            OPC_LUI: begin
                d.sel     = ALU_PASSB;
                d.op2_src = OP2_IMM;
            end
            OPC_AUIPC: begin
                d.op1_src = OP1_PC;
                d.op2_src = OP2_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                // Link address pc + 4
                d.op1_src = OP1_PC;
                d.op2_src = OP2_FOUR;
            end
            OPC_LOAD: begin
                d.op1_src = OP1_RS1;
                d.op2_src = OP2_IMM;
            end
            OPC_STORE: begin
                d.op1_src = OP1_RS1;
                d.op2_src = OP2_IMM;
                writes_rd = 1'b0;
            end
            OPC_BRANCH: begin
                // Branch target computation
                d.op1_src = OP1_PC;
                d.op2_src = OP2_IMM;
                writes_rd = 1'b0;
            end
            default: begin
                // Unknown opcode: zero operands, no writeback
                writes_rd = 1'b0;
            end
        endcase
        d.rd_we = writes_rd & (rd != 5'd0);
        return d;
    endfunction

    // Forwarding select: MEM beats WB; x0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [4:0]        idx,
        input logic [DATA_W-1:0] rf_val,
        input logic              mem_we,
        input logic [4:0]        mem_rd,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_we,
        input logic [4:0]        wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] val;
        if (mem_we && (mem_rd == idx) && (idx != 5'd0)) begin
            val = mem_data;
        end else if (wb_we && (wb_rd == idx) && (idx != 5'd0)) begin
            val = wb_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              valid_q,    valid_d;
    dec_t              dec_q,      dec_d;
    logic [4:0]        rd_q,       rd_d;
    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [4:0]        rs1_idx_q,  rs1_idx_d;
    logic [4:0]        rs2_idx_q,  rs2_idx_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;

    logic              in_ready_s;
    logic              capture_s;
    dec_t              dec_in_s;
    logic [DATA_W-1:0] rs1_fwd_s;
    logic [DATA_W-1:0] rs2_fwd_s;
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;

    assign in_ready_s = ~valid_q | out_ready;
    assign capture_s  = in_valid & in_ready_s & ~flush;
    assign dec_in_s   = decode(in_inst);

    // Next-state: flush beats capture beats consume/hold.
    always_comb begin
        valid_d    = valid_q;
        dec_d      = dec_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        rs1_idx_d  = rs1_idx_q;
        rs2_idx_d  = rs2_idx_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture_s) begin
            valid_d    = 1'b1;
            dec_d      = dec_in_s;
            rd_d       = in_inst[11:7];
            pc_d       = in_pc;
            rs1_idx_d  = in_inst[19:15];
            rs2_idx_d  = in_inst[24:20];
            rs1_data_d = in_rs1_data;
            rs2_data_d = in_rs2_data;
            imm_d      = in_imm;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register with asynchronous clear of every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            dec_q      <= '{sel: ALU_ADD, op1_src: OP1_ZERO, op2_src: OP2_ZERO, rd_we: 1'b0};
            rd_q       <= 5'd0;
            pc_q       <= CONST_ZERO;
            rs1_idx_q  <= 5'd0;
            rs2_idx_q  <= 5'd0;
            rs1_data_q <= CONST_ZERO;
            rs2_data_q <= CONST_ZERO;
            imm_q      <= CONST_ZERO;
        end else begin
            valid_q    <= valid_d;
            dec_q      <= dec_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            rs1_idx_q  <= rs1_idx_d;
            rs2_idx_q  <= rs2_idx_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
        end
    end

    // Forwarding on the held register indices, re-evaluated every cycle.
    always_comb begin
        rs1_fwd_s = fwd_pick(rs1_idx_q, rs1_data_q,
                             fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_we,  fwd_wb_rd,  fwd_wb_data);
        rs2_fwd_s = fwd_pick(rs2_idx_q, rs2_data_q,
                             fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_we,  fwd_wb_rd,  fwd_wb_data);
    end

    // Operand 1 source mux.
    always_comb begin
        op1_s = CONST_ZERO;
        case (dec_q.op1_src)
            OP1_RS1:  op1_s = rs1_fwd_s;
            OP1_PC:   op1_s = pc_q;
            OP1_ZERO: op1_s = CONST_ZERO;
            default:  op1_s = CONST_ZERO;
        endcase
    end

    // Operand 2 source mux.
    always_comb begin
        op2_s = CONST_ZERO;
        case (dec_q.op2_src)
            OP2_RS2:  op2_s = rs2_fwd_s;
            OP2_IMM:  op2_s = imm_q;
            OP2_FOUR: op2_s = CONST_FOUR;
            OP2_ZERO: op2_s = CONST_ZERO;
            default:  op2_s = CONST_ZERO;
        endcase
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = valid_q;
    assign alu_sel        = dec_q.sel;
    assign alu_op1        = op1_s;
    assign alu_op2        = op2_s;
    assign out_rd         = rd_q;
    assign out_rd_we      = dec_q.rd_we;
    assign out_pc         = pc_q;
    assign out_store_data = rs2_fwd_s;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes hand-computed
// expected beats into a queue, a monitor pops and compares on each handshake.
`timescale 1ns/1ps

module tb_alu_operand_stage;

    logic        clk, rst;
    logic        in_valid, in_ready, flush;
    logic [31:0] in_inst, in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_op1, alu_op2, out_pc, out_store_data;
    logic [4:0]  alu_sel, out_rd;
    logic        out_rd_we;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic [31:0] sd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_operand_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .flush(flush),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc),
        .out_store_data(out_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] sel, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [4:0] rd,
                                input logic rd_we, input logic [31:0] pc,
                                input logic [31:0] sd);
        exp_t e;
        e.sel = sel; e.op1 = op1; e.op2 = op2; e.rd = rd;
        e.rd_we = rd_we; e.pc = pc; e.sd = sd;
        return e;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm);
        in_inst = inst; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2; in_imm = imm;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
        fwd_mem_we = mwe; fwd_mem_rd = mrd; fwd_mem_data = md;
        fwd_wb_we = wwe; fwd_wb_rd = wrd; fwd_wb_data = wd;
    endtask

    // One beat with out_ready high; forwarding inputs stay as set by caller.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input exp_t e);
        drive(inst, pc, r1, r2, imm);
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: compare each handshaked beat against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got sel=%0d op1=0x%08h, expected no beat", alu_sel, alu_op1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_sel",   {27'd0, alu_sel},   {27'd0, e.sel});
                chk("mon_op1",   alu_op1,            e.op1);
                chk("mon_op2",   alu_op2,            e.op2);
                chk("mon_rd",    {27'd0, out_rd},    {27'd0, e.rd});
                chk("mon_rd_we", {31'd0, out_rd_we}, {31'd0, e.rd_we});
                chk("mon_pc",    out_pc,             e.pc);
                chk("mon_sdata", out_store_data,     e.sd);
            end
        end
    end

    // Watchdog bound on the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #12;
        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready},  32'd1);
        chk("rst_sel",      {27'd0, alu_sel},   32'd0);
        chk("rst_op1",      alu_op1,            32'd0);
        chk("rst_op2",      alu_op2,            32'd0);
        chk("rst_rd_we",    {31'd0, out_rd_we}, 32'd0);
        chk("rst_pc",       out_pc,             32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // add x3,x1,x2
        issue(32'h002081B3, 32'h10, 32'd5, 32'd7, 32'd0,
              mk(5'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'h10, 32'd7));
        // srai x4,x1,3 (rs2 field = 3, rs2 data 0x9)
        issue(32'h4030D213, 32'h14, 32'hF0, 32'h9, 32'd3,
              mk(5'd7, 32'hF0, 32'd3, 5'd4, 1'b1, 32'h14, 32'h9));
        // sub x5,x6,x7
        issue(32'h407302B3, 32'h18, 32'd20, 32'd8, 32'd0,
              mk(5'd1, 32'd20, 32'd8, 5'd5, 1'b1, 32'h18, 32'd8));
        // addi x6,x1,1024 (inst[30] = 1, still ADD)
        issue(32'h40008313, 32'h1C, 32'd3, 32'h44, 32'd1024,
              mk(5'd0, 32'd3, 32'd1024, 5'd6, 1'b1, 32'h1C, 32'h44));

        // Forwarding on add x5,x1,x2: MEM beats WB on rs1
        set_fwd(1'b1, 5'd1, 32'hAAAA, 1'b1, 5'd1, 32'hBBBB);
        issue(32'h002082B3, 32'h20, 32'h11, 32'h22, 32'd0,
              mk(5'd0, 32'hAAAA, 32'h22, 5'd5, 1'b1, 32'h20, 32'h22));
        // WB forwards rs2
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h1234);
        issue(32'h002082B3, 32'h24, 32'h11, 32'h22, 32'd0,
              mk(5'd0, 32'h11, 32'h1234, 5'd5, 1'b1, 32'h24, 32'h1234));
        // add x5,x0,x2 with MEM rd=0 we=1: x0 is never forwarded
        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        issue(32'h002002B3, 32'h28, 32'h55, 32'h66, 32'd0,
              mk(5'd0, 32'h55, 32'h66, 5'd5, 1'b1, 32'h28, 32'h66));
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Back-to-back: two beats on consecutive edges
        drive(32'h002081B3, 32'h30, 32'd1, 32'd2, 32'd0);
        in_valid = 1'b1;
        exp_q.push_back(mk(5'd0, 32'd1, 32'd2, 5'd3, 1'b1, 32'h30, 32'd2));
        @(posedge clk); #1;
        drive(32'h407302B3, 32'h34, 32'd10, 32'd3, 32'd0);
        exp_q.push_back(mk(5'd1, 32'd10, 32'd3, 5'd5, 1'b1, 32'h34, 32'd3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // jal x1 at pc 0x100
        issue(32'h000000EF, 32'h100, 32'h12, 32'd0, 32'h20,
              mk(5'd0, 32'h100, 32'd4, 5'd1, 1'b1, 32'h100, 32'd0));
        // sw x2,8(x1) with MEM forwarding rs2
        set_fwd(1'b1, 5'd2, 32'hCAFE, 1'b0, 5'd0, 32'd0);
        issue(32'h0020A423, 32'h104, 32'h1000, 32'h5, 32'd8,
              mk(5'd0, 32'h1000, 32'd8, 5'd8, 1'b0, 32'h104, 32'hCAFE));
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        // illegal opcode 1111111 with rd = 5
        issue(32'h000002FF, 32'h108, 32'h31, 32'h77, 32'h40,
              mk(5'd0, 32'd0, 32'd0, 5'd5, 1'b0, 32'h108, 32'h77));

        // Stall: held fields must not change, new beat not accepted
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h200, 32'd5, 32'd7, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(32'h407302B3, 32'h300, 32'h66, 32'h67, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {31'd0, in_ready},  32'd0);
            chk("stall_valid",    {31'd0, out_valid}, 32'd1);
            chk("stall_sel",      {27'd0, alu_sel},   32'd0);
            chk("stall_op1",      alu_op1,            32'd5);
            chk("stall_op2",      alu_op2,            32'd7);
            chk("stall_rd",       {27'd0, out_rd},    32'd3);
            chk("stall_pc",       out_pc,             32'h200);
            @(posedge clk); #1;
        end
        // Forwarded operand may change while stalled
        set_fwd(1'b1, 5'd1, 32'h999, 1'b0, 5'd0, 32'd0);
        #1;
        chk("stall_fwd_op1", alu_op1, 32'h999);
        // Flush with a beat offered
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("flush_valid",    {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready},  32'd1);

        // Flush beats capture on an empty stage
        out_ready = 1'b1;
        drive(32'h002081B3, 32'h400, 32'd9, 32'd9, 32'd0);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_cap_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("flush_cap_valid2", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h500, 32'd5, 32'd7, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_valid",    {31'd0, out_valid}, 32'd0);
        chk("arst_sel",      {27'd0, alu_sel},   32'd0);
        chk("arst_op1",      alu_op1,            32'd0);
        chk("arst_op2",      alu_op2,            32'd0);
        chk("arst_rd_we",    {31'd0, out_rd_we}, 32'd0);
        chk("arst_pc",       out_pc,             32'd0);
        chk("arst_in_ready", {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
